// File: rtl/decode_stage_pkg.sv
// Shared types for the RV32I decode stage: ALU control encodings, operand
// selects, opcode constants and the decoded bundle carried to execute.
package decode_stage_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        ADD     = 3'b000,
        L_SHIFT = 3'b001,
        SLT     = 3'b010,
        U_SLT   = 3'b011,
        XOR     = 3'b100,
        R_SHIFT = 3'b101,
        OR      = 3'b110,
        AND     = 3'b111
    } alu3_t;

    typedef enum logic [6:0] {
        I_STD = 7'b0000000,
        I_NEG = 7'b0100000
    } alu7_t;

    typedef enum logic [1:0] {
        SRC1_RS1  = 2'd0,
        SRC1_PC   = 2'd1,
        SRC1_ZERO = 2'd2
    } src1_sel_t;

    typedef enum logic {
        SRC2_RS2 = 1'b0,
        SRC2_IMM = 1'b1
    } src2_sel_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef struct packed {
        alu3_t           alu3;
        alu7_t           alu7;
        src1_sel_t       src1_sel;
        src2_sel_t       src2_sel;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            branch;
        logic            jump;
        logic            illegal;
        logic [XLEN-1:0] pc;
    } decode_bundle_t;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake plus decoded payload of the decode stage.
interface decode_stage_if;
    import decode_stage_pkg::*;

    logic            in_valid_i;
    logic            in_ready_o;
    logic [31:0]     instr_i;
    logic [XLEN-1:0] pc_i;
    logic            out_valid_o;
    logic            out_ready_i;
    alu3_t           alu3_o;
    alu7_t           alu7_o;
    src1_sel_t       src1_sel_o;
    src2_sel_t       src2_sel_o;
    logic [XLEN-1:0] imm_o;
    logic [4:0]      rs1_o;
    logic [4:0]      rs2_o;
    logic [4:0]      rd_o;
    logic            reg_write_o;
    logic            mem_read_o;
    logic            mem_write_o;
    logic            branch_o;
    logic            jump_o;
    logic            illegal_o;
    logic [XLEN-1:0] pc_o;

    // Decode stage view.
    modport slave (
        input  in_valid_i, instr_i, pc_i, out_ready_i,
        output in_ready_o, out_valid_o, alu3_o, alu7_o, src1_sel_o, src2_sel_o,
               imm_o, rs1_o, rs2_o, rd_o, reg_write_o, mem_read_o, mem_write_o,
               branch_o, jump_o, illegal_o, pc_o
    );

    // Surrounding pipeline view (fetch drives, execute consumes).
    modport master (
        output in_valid_i, instr_i, pc_i, out_ready_i,
        input  in_ready_o, out_valid_o, alu3_o, alu7_o, src1_sel_o, src2_sel_o,
               imm_o, rs1_o, rs2_o, rd_o, reg_write_o, mem_read_o, mem_write_o,
               branch_o, jump_o, illegal_o, pc_o
    );

endinterface

// File: rtl/decode_stage_instr_decoder.sv
// Pure combinational RV32I decoder: instruction word + PC -> decoded bundle.
module instr_decoder
    import decode_stage_pkg::*;
(
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    output decode_bundle_t  dec_o
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i_type;
    logic [XLEN-1:0] imm_s_type;
    logic [XLEN-1:0] imm_b_type;
    logic [XLEN-1:0] imm_u_type;
    logic [XLEN-1:0] imm_j_type;
    logic            writes_rd;

    assign opcode     = instr_i[6:0];
    assign funct3     = instr_i[14:12];
    assign funct7     = instr_i[31:25];
    assign imm_i_type = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s_type = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b_type = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u_type = {instr_i[31:12], 12'b0};
    assign imm_j_type = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    // Map opcode/funct fields to ALU control, operand selects, immediate and side effects.
    always_comb begin
        // NOTE: every field gets a default before the case so no path can infer a latch.
        dec_o          = '0;
        dec_o.alu3     = ADD;
        dec_o.alu7     = I_STD;
        dec_o.src1_sel = SRC1_RS1;
        dec_o.src2_sel = SRC2_RS2;
        dec_o.rs1      = instr_i[19:15];
        dec_o.rs2      = instr_i[24:20];
        dec_o.rd       = instr_i[11:7];
        dec_o.pc       = pc_i;
        writes_rd      = 1'b0;

        case (opcode)
            OPC_OP: begin
                dec_o.alu3 = alu3_t'(funct3);
                dec_o.alu7 = (funct7 == 7'b0100000) ? I_NEG : I_STD;
                writes_rd  = 1'b1;
                if (funct7 != 7'b0000000 && funct7 != 7'b0100000)
                    dec_o.illegal = 1'b1;
                else if (funct7 == 7'b0100000 && funct3 != 3'b000 && funct3 != 3'b101)
                    dec_o.illegal = 1'b1;
            end
            OPC_OP_IMM: begin
                dec_o.alu3     = alu3_t'(funct3);
                dec_o.src2_sel = SRC2_IMM;
                dec_o.imm      = imm_i_type;
                writes_rd      = 1'b1;
                if (funct3 == 3'b101) begin
                    // Shift-right type comes from imm[11:5].
                    if (funct7 == 7'b0100000) dec_o.alu7 = I_NEG;
                    else if (funct7 != 7'b0000000) dec_o.illegal = 1'b1;
                end else if (funct3 == 3'b001 && funct7 != 7'b0000000) begin
                    dec_o.illegal = 1'b1;
                end
            end
            OPC_LUI: begin
                dec_o.src1_sel = SRC1_ZERO;
                dec_o.src2_sel = SRC2_IMM;
                dec_o.imm      = imm_u_type;
                writes_rd      = 1'b1;
            end
            OPC_AUIPC: begin
                dec_o.src1_sel = SRC1_PC;
                dec_o.src2_sel = SRC2_IMM;
                dec_o.imm      = imm_u_type;
                writes_rd      = 1'b1;
            end
            OPC_LOAD: begin
                dec_o.src2_sel = SRC2_IMM;
                dec_o.imm      = imm_i_type;
                dec_o.mem_read = 1'b1;
                writes_rd      = 1'b1;
                if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)
                    dec_o.illegal = 1'b1;
            end
            OPC_STORE: begin
                dec_o.src2_sel  = SRC2_IMM;
                dec_o.imm       = imm_s_type;
                dec_o.mem_write = 1'b1;
                if (funct3 > 3'b010) dec_o.illegal = 1'b1;
            end
            OPC_BRANCH: begin
                dec_o.imm    = imm_b_type;
                dec_o.branch = 1'b1;
                case (funct3)
                    3'b000, 3'b001: dec_o.alu7 = I_NEG;
                    3'b100, 3'b101: dec_o.alu3 = SLT;
                    3'b110, 3'b111: dec_o.alu3 = U_SLT;
                    default:        dec_o.illegal = 1'b1;
                endcase
            end
            OPC_JAL: begin
                dec_o.src1_sel = SRC1_PC;
                dec_o.src2_sel = SRC2_IMM;
                dec_o.imm      = imm_j_type;
                dec_o.jump     = 1'b1;
                writes_rd      = 1'b1;
            end
            OPC_JALR: begin
                dec_o.src2_sel = SRC2_IMM;
                dec_o.imm      = imm_i_type;
                dec_o.jump     = 1'b1;
                writes_rd      = 1'b1;
                if (funct3 != 3'b000) dec_o.illegal = 1'b1;
            end
            default: dec_o.illegal = 1'b1;
        endcase

        // An illegal encoding is still delivered but must not cause any side effect.
        dec_o.reg_write = writes_rd && (dec_o.rd != 5'd0) && !dec_o.illegal;
        if (dec_o.illegal) begin
            dec_o.mem_read  = 1'b0;
            dec_o.mem_write = 1'b0;
            dec_o.branch    = 1'b0;
            dec_o.jump      = 1'b0;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode pipeline stage: registered ID/EX slot plus one skid entry so
// in_ready can be registered without losing throughput.
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           flush_i,
    decode_stage_if.slave  bus
);

    decode_bundle_t dec;
    decode_bundle_t out_q, out_d;
    decode_bundle_t skid_q, skid_d;
    logic           out_valid_q, out_valid_d;
    logic           skid_valid_q, skid_valid_d;
    logic           in_ready_q, in_ready_d;
    logic           accept;
    logic           drain;

    instr_decoder u_instr_decoder (
        .instr_i (bus.instr_i),
        .pc_i    (bus.pc_i),
        .dec_o   (dec)
    );

    assign accept = bus.in_valid_i && in_ready_q;
    assign drain  = out_valid_q && bus.out_ready_i;

    // Next-state of output slot and skid entry; flush discards both and drops any accept.
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || drain) begin
            // Skid is only ever full while in_ready is low, so no accept competes with it.
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = accept;
                if (accept) out_d = dec;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
        in_ready_d = !skid_valid_d;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: the payload flops are reset too so every output reads 0 out of reset.
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so all state updates see pre-edge values.
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign bus.in_ready_o  = in_ready_q;
    assign bus.out_valid_o = out_valid_q;
    assign bus.alu3_o      = out_q.alu3;
    assign bus.alu7_o      = out_q.alu7;
    assign bus.src1_sel_o  = out_q.src1_sel;
    assign bus.src2_sel_o  = out_q.src2_sel;
    assign bus.imm_o       = out_q.imm;
    assign bus.rs1_o       = out_q.rs1;
    assign bus.rs2_o       = out_q.rs2;
    assign bus.rd_o        = out_q.rd;
    assign bus.reg_write_o = out_q.reg_write;
    assign bus.mem_read_o  = out_q.mem_read;
    assign bus.mem_write_o = out_q.mem_write;
    assign bus.branch_o    = out_q.branch;
    assign bus.jump_o      = out_q.jump;
    assign bus.illegal_o   = out_q.illegal;
    assign bus.pc_o        = out_q.pc;

endmodule
